// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for the serial transmitter
// PARITY exists only when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - CLKS_PER_BIT down-counter with a one-cycle Tick on its last count
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Load,
  output logic Tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  // Auto-reload at zero so consecutive bit periods within DATA need no extra Load.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count <= 16'd0;
    end else if (Load || (count == 16'd0)) begin
      count <= RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  assign Tick = (count == 16'd0);

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed LSB-first serial transmitter with Valid/Ready payload intake
// Optional even-parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data,
  input  logic              Valid,
  output logic              Ready,
  output logic              TxD,
  output logic              Busy
);

  localparam logic [4:0] LAST_IDX = 5'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [4:0]        bit_idx;
  logic              txd_q;
  logic              tick;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  assign Ready   = (state == ST_IDLE);
  assign Busy    = ~Ready;
  assign accept  = Valid & Ready;
  assign shifted = shreg >> 1;
  assign TxD     = txd_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK  (CLK),
    .Reset(Reset),
    .Load (accept),
    .Tick (tick)
  );

  // TxD is loaded with the level of the state being entered, so it lines up with the state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      txd_q    <= IDLE_LEVEL;
      shreg    <= '0;
      bit_idx  <= 5'd0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (Valid) begin
            shreg    <= Data;
            bit_idx  <= 5'd0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^Data;
`endif
            txd_q    <= START_LEVEL;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd_q   <= shreg[0];
            bit_idx <= 5'd0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg <= shifted;
            if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
              txd_q <= parity_q;
              state <= ST_PARITY;
`else
              txd_q <= IDLE_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 5'd1;
              txd_q   <= shifted[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            txd_q <= IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            txd_q <= IDLE_LEVEL;
            state <= ST_IDLE;
          end
        end
        default: begin
          txd_q <= IDLE_LEVEL;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed bench for serial_tx (CLKS_PER_BIT=4 and CLKS_PER_BIT=1 instances)
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Valid;
  logic [7:0] Data;
  logic       TxD_a, Ready_a, Busy_a;
  logic       TxD_b, Ready_b, Busy_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .CLK(CLK), .Reset(Reset), .Data(Data), .Valid(Valid),
    .Ready(Ready_a), .TxD(TxD_a), .Busy(Busy_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
    .CLK(CLK), .Reset(Reset), .Data(Data), .Valid(Valid),
    .Ready(Ready_b), .TxD(TxD_b), .Busy(Busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit j: 0 start, 1..8 payload LSB first, then even parity if built in, then stop.
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (P == 1 && j == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int cpb, input bit on_b, input bit hold_ff);
    logic tx, rdy, bsy;
    Data  = d;
    Valid = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= (10 + P) * cpb; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        if (hold_ff) Data = 8'hFF;
        else Valid = 1'b0;
      end
      tx  = on_b ? TxD_b   : TxD_a;
      rdy = on_b ? Ready_b : Ready_a;
      bsy = on_b ? Busy_b  : Busy_a;
      check($sformatf("frame %0h cpb%0d cyc%0d txd", d, cpb, k), tx, exp_bit(d, (k - 1) / cpb));
      check($sformatf("frame %0h cpb%0d cyc%0d ready", d, cpb, k), rdy, 1'b0);
      check($sformatf("frame %0h cpb%0d cyc%0d busy", d, cpb, k), bsy, 1'b1);
    end
    @(negedge CLK);
    tx  = on_b ? TxD_b   : TxD_a;
    rdy = on_b ? Ready_b : Ready_a;
    bsy = on_b ? Busy_b  : Busy_a;
    check($sformatf("frame %0h end ready", d), rdy, 1'b1);
    check($sformatf("frame %0h end txd", d), tx, 1'b1);
    check($sformatf("frame %0h end busy", d), bsy, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    Valid = 1'b0;
    Data  = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset txd", TxD_a, 1'b1);
    check("reset ready", Ready_a, 1'b1);
    check("reset busy", Busy_a, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("idle %0d txd", i), TxD_a, 1'b1);
      check($sformatf("idle %0d ready", i), Ready_a, 1'b1);
      check($sformatf("idle %0d busy", i), Busy_a, 1'b0);
    end

    send_frame(8'hA5, 4, 1'b0, 1'b0);
    send_frame(8'h07, 4, 1'b0, 1'b0);

    // Data changes to FF with Valid held: 3C must go out intact, FF follows after one idle cycle.
    send_frame(8'h3C, 4, 1'b0, 1'b1);
    send_frame(8'hFF, 4, 1'b0, 1'b0);

    // Reset at cycle 15 of a frame.
    Data  = 8'h5A;
    Valid = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 1) Valid = 1'b0;
    end
    check("midframe cyc15 txd", TxD_a, exp_bit(8'h5A, 3));
    check("midframe cyc15 ready", Ready_a, 1'b0);
    Reset = 1'b1;
    @(negedge CLK);
    check("abort txd", TxD_a, 1'b1);
    check("abort ready", Ready_a, 1'b1);
    check("abort busy", Busy_a, 1'b0);
    Reset = 1'b0;
    @(negedge CLK);
    check("abort no resume txd", TxD_a, 1'b1);
    check("abort no resume ready", Ready_a, 1'b1);

    // Reset wins over a same-cycle offer.
    Data  = 8'h99;
    Valid = 1'b1;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    Valid = 1'b0;
    check("reset+valid ready", Ready_a, 1'b1);
    @(negedge CLK);
    check("dropped word ready", Ready_a, 1'b1);
    check("dropped word txd", TxD_a, 1'b1);

    send_frame(8'hC3, 4, 1'b0, 1'b0);

    send_frame(8'h81, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; the legal range is 1 to 32.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; the legal range is 1 to 65535.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port Data, input, DATA_W bits: parallel payload, sampled on acceptance.
REQ-006 Port Valid, input, 1 bit: the producer offers Data.
REQ-007 Port Ready, output, 1 bit: the transmitter can accept a word.
REQ-008 Port TxD, output, 1 bit: serial line; idles high; driven from a register.
REQ-009 Port Busy, output, 1 bit: a frame is in progress; equals the inverse of Ready.

Function
REQ-010 A word is accepted on a rising edge where Valid and Ready are both 1; Data is captured into an internal shift register at that edge.
REQ-011 Ready SHALL be 1 only in state IDLE; Valid while Ready=0 is ignored and does not queue.
REQ-012 FSM states are IDLE, START, DATA, PARITY and STOP.
REQ-013 IDLE goes to START on acceptance, START goes to DATA, DATA goes to PARITY (or STOP when parity is compiled out), PARITY goes to STOP, and STOP goes to IDLE.
REQ-014 Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a bit-tick counter that reloads on every state change.
REQ-015 TxD per state: IDLE=1, START=0, DATA=current bit (LSB first), PARITY=parity bit, STOP=1.
REQ-016 DATA lasts DATA_W bit periods; the shift register shifts right once per bit period; a bit index counts 0..DATA_W-1.
REQ-017 Latency: TxD falls on the first cycle after the acceptance edge.
REQ-018 Frame length is (2 + DATA_W + P) × CLKS_PER_BIT cycles, where P = 1 with parity compiled in and P = 0 otherwise.
REQ-019 Ready returns to 1 on the cycle after the last STOP cycle.
REQ-020 Minimum inter-frame gap is one IDLE cycle with TxD=1, even with Valid held continuously high.
REQ-021 Changes to Data after acceptance SHALL NOT affect the frame in flight.
REQ-022 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle; the counter must not underflow.

Reset
REQ-023 On a rising edge with Reset=1: state=IDLE, TxD=1, Ready=1, Busy=0, counters=0, shift register=0.
REQ-024 Reset mid-frame aborts the frame; TxD is 1 from the next cycle and no partial bits resume.
REQ-025 Reset has priority over acceptance in the same cycle; the offered word is dropped.

Configuration
REQ-026 Macro SERIAL_TX_PARITY_EN: when defined, the PARITY state emits the even-parity bit (XOR of the captured payload), computed at acceptance.
REQ-027 When SERIAL_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and DATA proceeds directly to STOP.

Structure
REQ-028 Package serial_pkg SHALL hold the state enum type tx_state_t and the constants IDLE_LEVEL=1 and START_LEVEL=0.
REQ-029 Sub-module bit_timer SHALL hold the CLKS_PER_BIT down-counter, with inputs CLK, Reset and Load and a one-cycle Tick output on its last count.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-030 Apply Reset for 2 cycles, then release -> TxD=1, Ready=1, Busy=0 and no transitions for 20 cycles.
REQ-031 Send Data=0xA5 without parity -> TxD emits bits 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; the frame is 40 cycles; Ready=1 at cycle 41.
REQ-032 Send 0xA5 with SERIAL_TX_PARITY_EN defined -> parity bit 0 before the stop bit; send 0x07 -> parity bit 1; each frame is 44 cycles.
REQ-033 Send 0x3C, then drive Data=0xFF with Valid=1 during the frame -> the frame carries 0x3C exactly; 0xFF is accepted only after Ready returns, following one IDLE cycle with TxD=1.
REQ-034 Assert Reset at cycle 15 of a frame -> TxD=1 and Ready=1 on the following cycle; the next word sends a complete, correct frame.
REQ-035 With CLKS_PER_BIT=1, send 0x81 -> TxD emits bits 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; the frame is 10 cycles.
